// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, memory handshake stalls.
// Optional memory-stall timeout with a sticky error state is enabled by defining PIPE_STALL_TIMEOUT_EN.
module pipe_hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rd_i,
   input  logic [4:0]       ifid_rs1_i,
   input  logic [4:0]       ifid_rs2_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             pipe_en_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      MSTALL = 2'd2,
      ERR    = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             hazard_s;
   logic             memwait_s;

   // Parameter sanity is checked while elaborating, so a bad build never reaches silicon.
   if (TIMEOUT < 1 || CNT_W < 1) begin : g_param_chk
      $error("pipe_hazard_ctrl: TIMEOUT and CNT_W must be at least 1");
   end

`ifdef PIPE_STALL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_q, err_d;
`endif

   // Hazard and memory-wait decode from the current pipeline inputs.
   always_comb begin
      hazard_s  = idex_memread_i && (idex_rd_i != 5'd0) &&
                  ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
      memwait_s = dmem_req_i && !dmem_ack_i;
   end

   // Next-state and control outputs; everything defaults to a frozen pipeline.
   always_comb begin
      state_d      = state_q;
      pc_we_o      = 1'b0;
      ifid_we_o    = 1'b0;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      pipe_en_o    = 1'b0;
`ifdef PIPE_STALL_TIMEOUT_EN
      to_cnt_d     = {TO_W{1'b0}};
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN, MSTALL: begin
            if (!start_i) begin
               state_d = IDLE;
            end else if ((state_q == MSTALL) && !dmem_ack_i) begin
               state_d = MSTALL;
`ifdef PIPE_STALL_TIMEOUT_EN
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_d == TO_W'(TIMEOUT)) begin
                  state_d = ERR;
               end else begin
                  state_d = MSTALL;
               end
`endif
            end else if (memwait_s) begin
               state_d = MSTALL;
            end else begin
               // An ack in MSTALL lands here too: the cycle behaves exactly like RUN.
               state_d   = RUN;
               pipe_en_o = 1'b1;
               if (hazard_s) begin
                  idex_flush_o = 1'b1;
               end else begin
                  pc_we_o      = 1'b1;
                  ifid_we_o    = 1'b1;
                  ifid_flush_o = branch_taken_i;
               end
            end
         end
`ifdef PIPE_STALL_TIMEOUT_EN
         ERR: begin
            state_d = ERR;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Saturating count of cycles in which the PC was held while the pipeline was active.
   always_comb begin
      if (((state_q == RUN) || (state_q == MSTALL)) && !pc_we_o &&
          (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and stall counter registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef PIPE_STALL_TIMEOUT_EN
   // Error flag is sticky and rises together with the ERR state.
   always_comb begin
      if (state_d == ERR) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Timeout counter and error flag registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         to_cnt_q <= {TO_W{1'b0}};
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model pushes expected outputs each cycle,
// compared mid-cycle against the DUT; a second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_STALL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TMO = 4;

   logic clk_i = 1'b0;
   logic rst_i;
   logic start_i, idex_memread_i, branch_taken_i, dmem_req_i, dmem_ack_i;
   logic [4:0] idex_rd_i, ifid_rs1_i, ifid_rs2_i;
   logic pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, pipe_en_o, err_o;
   logic [1:0] state_o;
   logic [15:0] stall_cnt_o;
   logic u2_pc_we, u2_ifid_we, u2_ifid_flush, u2_idex_flush, u2_pipe_en, u2_err;
   logic [1:0] u2_state, u2_cnt;

   always #5 clk_i = ~clk_i;

   pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
      .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
      .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
      .idex_flush_o(idex_flush_o), .pipe_en_o(pipe_en_o), .state_o(state_o),
      .stall_cnt_o(stall_cnt_o), .err_o(err_o));

   pipe_hazard_ctrl #(.CNT_W(2), .TIMEOUT(TMO)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
      .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
      .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_we_o(u2_pc_we), .ifid_we_o(u2_ifid_we), .ifid_flush_o(u2_ifid_flush),
      .idex_flush_o(u2_idex_flush), .pipe_en_o(u2_pipe_en), .state_o(u2_state),
      .stall_cnt_o(u2_cnt), .err_o(u2_err));

   // {state, pc_we, ifid_we, ifid_flush, idex_flush, pipe_en, err, cnt16, cnt2}
   typedef logic [25:0] exp_t;
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [1:0]  m_st;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;
   int          m_to;
   logic        m_err;
   logic        e_pc, e_ifw, e_iff, e_idf, e_pe;
   logic [1:0]  e_nxt;
   int          e_to;

   function automatic logic [19:0] mk(input logic st, input logic mr, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic br, input logic req, input logic ack);
      return {st, mr, rd, rs1, rs2, br, req, ack};
   endfunction

   task automatic model_eval();
      logic hz, mw;
      hz = idex_memread_i && (idex_rd_i != 5'd0) &&
           ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
      mw = dmem_req_i && !dmem_ack_i;
      {e_pc, e_ifw, e_iff, e_idf, e_pe} = 5'b0;
      e_to  = 0;
      e_nxt = m_st;
      if (m_st == 2'd0) e_nxt = start_i ? 2'd1 : 2'd0;
      else if (m_st == 2'd3) e_nxt = 2'd3;
      else if (!start_i) e_nxt = 2'd0;
      else if (m_st == 2'd2 && !dmem_ack_i) begin
         e_nxt = 2'd2;
         e_to  = m_to + 1;
         if (TMO_EN && e_to == TMO) e_nxt = 2'd3;
      end else if (mw) e_nxt = 2'd2;
      else begin
         e_nxt = 2'd1;
         e_pe  = 1'b1;
         if (hz) e_idf = 1'b1;
         else begin
            e_pc  = 1'b1;
            e_ifw = 1'b1;
            e_iff = branch_taken_i;
         end
      end
   endtask

   task automatic model_tick();
      model_eval();
      if ((m_st == 2'd1 || m_st == 2'd2) && !e_pc) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      if (e_nxt == 2'd3) m_err = 1'b1;
      m_to = e_to;
      m_st = e_nxt;
   endtask

   task automatic model_reset();
      m_st = 2'd0; m_cnt = 16'd0; m_cnt2 = 2'd0; m_to = 0; m_err = 1'b0;
      sb_q.delete();
   endtask

   task automatic drive(input logic [19:0] v);
      {start_i, idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
       branch_taken_i, dmem_req_i, dmem_ack_i} = v;
   endtask

   // One clock: advance the model on the edge, apply new inputs, queue the expectation, sample at negedge.
   task automatic step(input logic [19:0] v);
      @(posedge clk_i);
      model_tick();
      #1;
      drive(v);
      model_eval();
      sb_q.push_back({m_st, e_pc, e_ifw, e_iff, e_idf, e_pe, m_err, m_cnt, m_cnt2});
      @(negedge clk_i);
   endtask

   function automatic exp_t observed();
      return {state_o, pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, pipe_en_o, err_o,
              stall_cnt_o, u2_cnt};
   endfunction

   task automatic test_reset();
      exp_t o;
      rst_i = 1'b0;
      drive(20'd0);
      model_reset();
      repeat (2) @(negedge clk_i);
      o = observed();
      n_cmp++;
      if (o !== 26'd0) begin
         n_bad++;
         $display("FAIL reset: got %h want %h", o, 26'd0);
      end
      #1 rst_i = 1'b1;
   endtask

   task automatic test_run();
      exp_t e, o;
      for (int i = 0; i < 4; i++) begin
         step(mk(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0));
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL run[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_hazard();
      logic [19:0] stim[6];
      exp_t e, o;
      stim[0] = mk(1, 1, 5'd5, 5'd0, 5'd5, 1, 0, 0);   // load-use on rs2, beats branch
      stim[1] = mk(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);   // rd=x0 never stalls, branch flushes
      stim[2] = mk(1, 1, 5'd9, 5'd3, 5'd4, 0, 0, 0);
      stim[3] = mk(1, 1, 5'd7, 5'd7, 5'd2, 0, 0, 0);   // load-use on rs1
      stim[4] = mk(1, 0, 5'd7, 5'd7, 5'd7, 1, 0, 0);   // not a load: branch only
      stim[5] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      foreach (stim[i]) begin
         step(stim[i]);
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL hazard[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_memstall();
      logic [19:0] stim[9];
      exp_t e, o;
      for (int i = 0; i < 3; i++) stim[i] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      stim[3] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);   // ack releases the stall
      stim[4] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      stim[5] = mk(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1);   // req+ack in RUN is not a stall
      stim[6] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      stim[7] = mk(1, 1, 5'd3, 5'd3, 5'd0, 1, 1, 1);   // ack cycle with a load-use hazard
      stim[8] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      foreach (stim[i]) begin
         step(stim[i]);
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL memstall[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_stop();
      logic [19:0] stim[8];
      exp_t e, o;
      stim[0] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);   // stop in RUN
      stim[1] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      stim[2] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      stim[3] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      stim[4] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);   // stop in MSTALL
      stim[5] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      stim[6] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      stim[7] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      foreach (stim[i]) begin
         step(stim[i]);
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL stop[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_saturate();
      exp_t e, o;
      for (int i = 0; i < 7; i++) begin
         step((i < 5) ? mk(1, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0) : mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0));
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL saturate[%0d]: got %h want %h", i, o, e); end
      end
      n_cmp++;
      if (u2_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_cnt2: got %0d want 3", u2_cnt); end
   endtask

   task automatic test_async_reset();
      exp_t e, o;
      for (int i = 0; i < 3; i++) begin
         step((i == 0) ? mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0) : mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0));
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL pre_arst[%0d]: got %h want %h", i, o, e); end
      end
      #2 rst_i = 1'b0;
      #1;
      o = observed();
      n_cmp++;
      if (o !== 26'd0) begin n_bad++; $display("FAIL async_reset: got %h want %h", o, 26'd0); end
      model_reset();
      drive(20'd0);
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0));
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL post_arst[%0d]: got %h want %h", i, o, e); end
      end
   endtask

   task automatic test_timeout();
      exp_t e, o;
      for (int i = 0; i < 10; i++) begin
         step(mk((i < 7) ? 1'b1 : 1'b0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0));
         e = sb_q.pop_front(); o = observed(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL timeout[%0d]: got %h want %h", i, o, e); end
      end
      n_cmp++;
      if (state_o !== (TMO_EN ? 2'd3 : 2'd0)) begin
         n_bad++;
         $display("FAIL timeout_state: got %0d want %0d", state_o, TMO_EN ? 2'd3 : 2'd0);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_hazard();
      test_memstall();
      test_stop();
      test_saturate();
      test_async_reset();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
